divider: RTL

Iterative 32-bit integer divider for the ARM CPU execute stage; it is the inverse unit of the two-cycle pipelined multiplier. It accepts a dividend/divisor pair under a start/busy/done handshake and computes quotient and remainder using one restoring-division step per clock. Results follow ARMv7 UDIV/SDIV semantics, with the remainder added for MLS-style use.

---
 rtl/cpu_div_pkg.sv | 11 +
 rtl/divider_step.sv | 28 ++
 rtl/divider.sv | 118 +++++++++++
 3 files changed

// File: rtl/cpu_div_pkg.sv
// Shared types and constants for the execute-stage iterative divider.
package cpu_div_pkg;
   localparam int unsigned DIV_WIDTH = 32;
   localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } div_state_t;
endpackage

// File: rtl/divider_step.sv
// One combinational restoring-division iteration on {rem, quo} against the divisor.
module divider_step
   import cpu_div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] div_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   always_comb begin
      shifted = {rem_i, quo_i[WIDTH-1]};
      trial   = shifted - {1'b0, div_i};
      // rem_i < div_i always holds, so a non-negative trial fits in WIDTH bits
      if (!trial[WIDTH]) begin
         rem_o = trial[WIDTH-1:0];
         quo_o = {quo_i[WIDTH-2:0], 1'b1};
      end else begin
         rem_o = shifted[WIDTH-1:0];
         quo_o = {quo_i[WIDTH-2:0], 1'b0};
      end
   end
endmodule

// File: rtl/divider.sv
// Iterative UDIV/SDIV divider with remainder, one restoring step per clock.
// Define DIVIDER_SIGNED_EN to honour signed_op; otherwise every operation is unsigned.
module divider
   import cpu_div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);
   localparam int unsigned CNT_W = $clog2(WIDTH);

   div_state_t       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] rem_q, quo_q, div_q;
   logic             dz_q, busy_q, done_q;
   logic [WIDTH-1:0] quot_out_q, rem_out_q;

   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH-1:0] step_rem, step_quo;
   logic [WIDTH-1:0] rem_sel, fix_quo, fix_rem;

   // On divide-by-zero the dividend magnitude is still parked in quo_q
   assign rem_sel = dz_q ? quo_q : rem_q;

`ifdef DIVIDER_SIGNED_EN
   logic sgn_a, sgn_b;
   logic neg_quo_q, neg_rem_q;

   assign sgn_a   = signed_op & a[WIDTH-1];
   assign sgn_b   = signed_op & b[WIDTH-1];
   assign mag_a   = sgn_a ? -a : a;
   assign mag_b   = sgn_b ? -b : b;
   assign fix_quo = neg_quo_q ? -quo_q : quo_q;
   assign fix_rem = neg_rem_q ? -rem_sel : rem_sel;
`else
   logic unused_signed_op;

   assign unused_signed_op = signed_op;
   assign mag_a   = a;
   assign mag_b   = b;
   assign fix_quo = quo_q;
   assign fix_rem = rem_sel;
`endif

   divider_step #(.WIDTH(WIDTH)) u_step (
      .rem_i (rem_q),
      .quo_i (quo_q),
      .div_i (div_q),
      .rem_o (step_rem),
      .quo_o (step_quo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         div_q      <= '0;
         dz_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         quot_out_q <= '0;
         rem_out_q  <= '0;
`ifdef DIVIDER_SIGNED_EN
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  quo_q   <= mag_a;
                  div_q   <= mag_b;
                  rem_q   <= '0;
                  cnt_q   <= CNT_W'(WIDTH - 1);
                  dz_q    <= (b == '0);
                  busy_q  <= 1'b1;
                  state_q <= (b == '0) ? FIX : CALC;
`ifdef DIVIDER_SIGNED_EN
                  neg_quo_q <= sgn_a ^ sgn_b;
                  neg_rem_q <= sgn_a;
`endif
               end
            end
            CALC: begin
               rem_q <= step_rem;
               quo_q <= step_quo;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == '0) state_q <= FIX;
            end
            FIX: begin
               quot_out_q <= dz_q ? '0 : fix_quo;
               rem_out_q  <= fix_rem;
               done_q     <= 1'b1;
               busy_q     <= 1'b0;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign quotient  = quot_out_q;
   assign remainder = rem_out_q;
endmodule
